// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: direct and indirect (LDI/STI) dcache
// accesses, MMIO window bypass, response timeout and a saturating stall counter.
module dmem_access_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 16'hFFF6,
  parameter int                TIMEOUT   = 64,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall,
  output logic              mmio_sel,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic              squash,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_IND, S_ACC2} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [TW-1:0]     r_timer;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_mem, w_in_store, w_in_load, w_go, w_in_mmio;
  logic w_r_store, w_r_ind, w_ptr_mmio, w_tmo;

  assign w_in_mem   = opcode inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI, OP_TRAP};
  assign w_in_store = opcode inside {OP_STR, OP_STB};
  assign w_in_load  = opcode inside {OP_LDR, OP_LDB, OP_TRAP, OP_LDI};
  assign w_go       = valid && w_in_mem;
  assign w_in_mmio  = addr >= MMIO_BASE;

  // Opcode is latched at issue so later phases never depend on upstream inputs.
  assign w_r_store  = r_op inside {OP_STR, OP_STB};
  assign w_r_ind    = r_op inside {OP_LDI, OP_STI};
  assign w_ptr_mmio = r_ptr >= MMIO_BASE;
  assign w_tmo      = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1)) && !mem_resp;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go && !w_in_mmio) w_next = S_ACC1;
      S_ACC1: begin
        if (mem_resp)   w_next = w_r_ind ? S_IND : S_IDLE;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_IND:  w_next = w_ptr_mmio ? S_IDLE : S_ACC2;
      S_ACC2: if (mem_resp || w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    stall       = 1'b0;
    mmio_sel    = 1'b0;
    mmio_addr   = '0;
    squash      = 1'b0;
    timeout_err = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_in_mmio) begin
              mmio_addr = addr;
              mmio_sel  = w_in_load;
            end else begin
              mem_req  = 1'b1;
              mem_addr = addr;
              mem_we   = w_in_store;
              stall    = 1'b1;
            end
          end
        end
        S_ACC1: begin
          mem_req  = 1'b1;
          mem_addr = r_addr;
          mem_we   = w_r_store;
          if (mem_resp) begin
            stall  = w_r_ind;
            squash = (r_op == OP_TRAP);
          end else if (w_tmo) begin
            timeout_err = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        S_IND: begin
          if (w_ptr_mmio) begin
            mmio_addr = r_ptr;
            mmio_sel  = (r_op == OP_LDI);
          end else begin
            stall = 1'b1;
          end
        end
        S_ACC2: begin
          mem_req  = 1'b1;
          mem_addr = r_ptr;
          mem_we   = (r_op == OP_STI);
          if (!mem_resp) begin
            if (w_tmo) timeout_err = 1'b1;
            else       stall       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_ptr       <= '0;
      r_timer     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_go) begin
        r_op   <= opcode;
        r_addr <= addr;
      end
      if (r_state == S_ACC1 && mem_resp) r_ptr <= mem_rdata[ADDR_W-1:0];
      if ((r_state == S_ACC1 || r_state == S_ACC2) && w_next == r_state)
        r_timer <= r_timer + 1'b1;
      else
        r_timer <= '0;
      if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = rst ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Cycle-level scoreboard bench for dmem_access_ctrl (default DUT plus a TIMEOUT=4 copy).
module tb_dmem_access_ctrl;

  localparam logic       H = 1'b1;
  localparam logic       L = 1'b0;
  localparam logic [15:0] Z16 = 16'h0000;
  localparam logic [3:0] LDB = 4'b0010, STB = 4'b0011, LDR = 4'b0110, STR = 4'b0111;
  localparam logic [3:0] LDI = 4'b1010, STI = 4'b1011, TRAP = 4'b1111, BAD = 4'b0001;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic        stall;
    logic        sel;
    logic [15:0] maddr;
    logic        sq;
    logic        terr;
  } outs_t;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [3:0]  op;
    logic [15:0] a;
    logic        resp;
    logic [15:0] rd;
    outs_t       e;
  } step_t;

  logic        clk = 1'b0;
  logic        rst, valid, mem_resp;
  logic [3:0]  opcode;
  logic [15:0] addr, mem_rdata;

  logic        mem_req, mem_we, stall, mmio_sel, squash, timeout_err;
  logic [15:0] mem_addr, mmio_addr;
  logic [31:0] stall_cnt;

  logic        t_mem_req, t_mem_we, t_stall, t_mmio_sel, t_squash, t_timeout_err;
  logic [15:0] t_mem_addr, t_mmio_addr;
  logic [31:0] t_stall_cnt;

  int    n_tests = 0;
  int    n_fail  = 0;
  outs_t sb[$];

  always #5 clk = ~clk;

  dmem_access_ctrl u_dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .addr(addr),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .stall(stall),
    .mmio_sel(mmio_sel), .mmio_addr(mmio_addr), .squash(squash),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .addr(addr),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .stall(t_stall),
    .mmio_sel(t_mmio_sel), .mmio_addr(t_mmio_addr), .squash(t_squash),
    .timeout_err(t_timeout_err), .stall_cnt(t_stall_cnt)
  );

  function automatic outs_t o(input logic req, input logic we, input logic [15:0] ad,
                              input logic st, input logic sel, input logic [15:0] ma,
                              input logic sq, input logic te);
    outs_t x;
    x = {req, we, ad, st, sel, ma, sq, te};
    return x;
  endfunction

  function automatic step_t stp(input logic r, input logic v, input logic [3:0] op,
                                input logic [15:0] a, input logic resp,
                                input logic [15:0] rd, input outs_t e);
    step_t s;
    s = {r, v, op, a, resp, rd, e};
    return s;
  endfunction

  function automatic outs_t obs_m();
    outs_t x;
    x = {mem_req, mem_we, mem_addr, stall, mmio_sel, mmio_addr, squash, timeout_err};
    return x;
  endfunction

  function automatic outs_t obs_t();
    outs_t x;
    x = {t_mem_req, t_mem_we, t_mem_addr, t_stall, t_mmio_sel, t_mmio_addr, t_squash, t_timeout_err};
    return x;
  endfunction

  // Drives one cycle of stimulus after the falling edge and queues its expectation.
  task automatic apply(input step_t s);
    @(negedge clk);
    rst = s.r; valid = s.v; opcode = s.op; addr = s.a; mem_resp = s.resp; mem_rdata = s.rd;
    sb.push_back(s.e);
    #2;
  endtask

  task automatic test_reset();
    outs_t ex;
    apply(stp(H, H, LDR, 16'h1000, H, Z16, '0));
    ex = sb.pop_front();
    n_tests++;
    if (obs_m() !== ex) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected %h", obs_m(), ex);
    end
    n_tests++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt);
    end
  endtask

  task automatic test_ldr();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, LDR, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h1234, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h5678, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h5678, H, 16'hBEEF, o(H, L, 16'h1000, L, L, Z16, L, L)));
    s.push_back(stp(L, L, LDR, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL ldr step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
    n_tests++;
    if (stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL ldr_stall_cnt: got %0d, expected 3", stall_cnt);
    end
  endtask

  task automatic test_sti();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, STI, Z16, L, Z16, '0));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, H, 16'h3000, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(L, L, Z16, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(H, H, 16'h3000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, H, Z16, o(H, H, 16'h3000, L, L, Z16, L, L)));
    s.push_back(stp(L, L, STI, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL sti step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
    n_tests++;
    if (stall_cnt !== 32'd5) begin
      n_fail++; $display("FAIL sti_stall_cnt: got %0d, expected 5", stall_cnt);
    end
  endtask

  task automatic test_ldi_mmio();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, LDI, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDI, 16'h2000, L, Z16, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDI, 16'h2000, H, 16'hFFF8, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDI, 16'h2000, H, 16'h1111, o(L, L, Z16, L, H, 16'hFFF8, L, L)));
    s.push_back(stp(L, L, LDI, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL ldi_mmio step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
  endtask

  task automatic test_mmio_direct();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, LDR, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDR, 16'hFFF6, L, Z16, o(L, L, Z16, L, H, 16'hFFF6, L, L)));
    s.push_back(stp(L, H, STB, 16'hFFFF, L, Z16, o(L, L, Z16, L, L, 16'hFFFF, L, L)));
    s.push_back(stp(L, H, LDR, 16'hFFF5, L, Z16, o(H, L, 16'hFFF5, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'hFFF5, H, Z16, o(H, L, 16'hFFF5, L, L, Z16, L, L)));
    s.push_back(stp(L, H, BAD, 16'h1000, L, Z16, '0));
    s.push_back(stp(L, L, LDR, 16'h1000, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL mmio_direct step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
  endtask

  task automatic test_trap();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, TRAP, Z16, L, Z16, '0));
    s.push_back(stp(L, H, TRAP, 16'h0020, L, Z16, o(H, L, 16'h0020, H, L, Z16, L, L)));
    s.push_back(stp(L, H, TRAP, 16'h0020, H, 16'h4000, o(H, L, 16'h0020, L, L, Z16, H, L)));
    s.push_back(stp(L, L, TRAP, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL trap step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, LDB, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDB, 16'h0100, L, Z16, o(H, L, 16'h0100, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDB, 16'h0100, H, Z16, o(H, L, 16'h0100, L, L, Z16, L, L)));
    s.push_back(stp(L, H, STR, 16'h0200, L, Z16, o(H, H, 16'h0200, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STR, 16'h0200, H, Z16, o(H, H, 16'h0200, L, L, Z16, L, L)));
    s.push_back(stp(L, L, STR, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
  endtask

  task automatic test_rst_acc2();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, STI, Z16, L, Z16, '0));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, H, 16'h3000, o(H, L, 16'h2000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(L, L, Z16, H, L, Z16, L, L)));
    s.push_back(stp(L, H, STI, 16'h2000, L, Z16, o(H, H, 16'h3000, H, L, Z16, L, L)));
    s.push_back(stp(H, H, STI, 16'h2000, L, Z16, '0));
    s.push_back(stp(L, L, STI, Z16, H, 16'h3000, '0));
    s.push_back(stp(L, L, STI, Z16, L, Z16, '0));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_m() !== ex) begin
        n_fail++; $display("FAIL rst_acc2 step %0d: got %h, expected %h", i, obs_m(), ex);
      end
    end
    n_tests++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_acc2_stall_cnt: got %0d, expected 0", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    outs_t ex;
    s.push_back(stp(H, L, LDR, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, H, L, Z16, L, L)));
    s.push_back(stp(L, H, LDR, 16'h1000, L, Z16, o(H, L, 16'h1000, L, L, Z16, L, H)));
    s.push_back(stp(L, L, LDR, Z16, L, Z16, '0));
    s.push_back(stp(L, H, LDR, 16'hFFF6, L, Z16, o(L, L, Z16, L, H, 16'hFFF6, L, L)));
    foreach (s[i]) begin
      apply(s[i]);
      ex = sb.pop_front();
      n_tests++;
      if (obs_t() !== ex) begin
        n_fail++; $display("FAIL timeout step %0d: got %h, expected %h", i, obs_t(), ex);
      end
    end
    n_tests++;
    if (t_stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL timeout_stall_cnt: got %0d, expected 4", t_stall_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; opcode = 4'h0; addr = Z16; mem_resp = 1'b0; mem_rdata = Z16;
    test_reset();
    test_ldr();
    test_sti();
    test_ldi_mmio();
    test_mmio_direct();
    test_trap();
    test_back_to_back();
    test_rst_acc2();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
